// File: rtl/mux_pkg.sv
// Shared arbitration-mode constants for the mux/arbiter family.
package mux_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/mux.sv
// Generic N:1 combinational data select over a flat bus; channel k at [k*WIDTH +: WIDTH].
// Zero latency, no flow control.
module mux #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 3
) (
  input  logic [WIDTH*(1<<SIZE)-1:0] in,
  input  logic [SIZE-1:0]            sel,
  output logic [WIDTH-1:0]           out
);

  localparam int N = 1 << SIZE;

  always_comb begin
    out = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SIZE'(i)) out = in[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational grant: first requester searching up from pointer (round-robin) or from 0 (fixed).
// Zero latency; grant is all-zero when nothing requests.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int        SIZE = 3,
  parameter arb_mode_e MODE = ARB_RR
) (
  input  logic [(1<<SIZE)-1:0] request,
  input  logic [SIZE-1:0]      pointer,
  output logic [(1<<SIZE)-1:0] grant,
  output logic [SIZE-1:0]      grant_idx
);

  localparam int N = 1 << SIZE;

  logic             found;
  logic [SIZE-1:0]  cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      // SIZE-bit addition wraps N-1 back to 0 for free.
      cand = (MODE == ARB_RR) ? pointer + SIZE'(i) : SIZE'(i);
      if (!found && request[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Arbitrated N:1 mux into a one-entry output register; 1-cycle latency, 1 beat/cycle.
// Backpressure: in_ready drops to zero whenever the held beat is not being consumed.
module arb_mux
  import mux_pkg::*;
#(
  parameter int        WIDTH = 8,
  parameter int        SIZE  = 3,
  parameter arb_mode_e MODE  = ARB_RR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH*(1<<SIZE)-1:0] in,
  input  logic [(1<<SIZE)-1:0]       in_valid,
  output logic [(1<<SIZE)-1:0]       in_ready,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIZE-1:0]            out_sel
);

  logic                 rst_q;
  logic [SIZE-1:0]      ptr;
  logic [(1<<SIZE)-1:0] grant;
  logic [SIZE-1:0]      grant_idx;
  logic [WIDTH-1:0]     sel_dat;
  logic                 reg_free;
  logic                 xfer;

  rr_arbiter #(
    .SIZE (SIZE),
    .MODE (MODE)
  ) u_arb (
    .request   (in_valid),
    .pointer   (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  mux #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_mux (
    .in  (in),
    .sel (grant_idx),
    .out (sel_dat)
  );

  assign reg_free = !out_valid || out_ready;
  // rst_q holds off transfers on the edge that samples reset release.
  assign xfer     = reset && rst_q && reg_free && (|in_valid);
  assign in_ready = xfer ? grant : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_q     <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      rst_q <= 1'b1;
      if (xfer) begin
        out_valid <= 1'b1;
        out       <= sel_dat;
        out_sel   <= grant_idx;
        ptr       <= grant_idx + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Randomized and directed check of arb_mux (RR and FIXED side by side) against a queue-free behavioural model.
module tb_arb_mux;
  import mux_pkg::*;

  localparam int W = 3;
  localparam int S = 3;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [W*N-1:0] in_bus;
  logic [N-1:0]   in_valid;
  logic           out_ready;

  logic [N-1:0]   rr_in_ready, fx_in_ready;
  logic [W-1:0]   rr_out, fx_out;
  logic           rr_out_valid, fx_out_valid;
  logic [S-1:0]   rr_out_sel, fx_out_sel;

  int checks = 0;
  int failures = 0;

  // Model state per mode: index 0 = round-robin, 1 = fixed priority.
  bit m_active [2];
  bit m_vld    [2];
  int m_dat    [2];
  int m_sel    [2];
  int m_ptr    [2];

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(W), .SIZE(S), .MODE(ARB_RR)) dut_rr (
    .clk(clk), .reset(reset), .in(in_bus), .in_valid(in_valid),
    .in_ready(rr_in_ready), .out(rr_out), .out_valid(rr_out_valid),
    .out_ready(out_ready), .out_sel(rr_out_sel)
  );

  arb_mux #(.WIDTH(W), .SIZE(S), .MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .reset(reset), .in(in_bus), .in_valid(in_valid),
    .in_ready(fx_in_ready), .out(fx_out), .out_valid(fx_out_valid),
    .out_ready(out_ready), .out_sel(fx_out_sel)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int m, input logic [N-1:0] iv);
    int start;
    start = (m == 0) ? m_ptr[m] : 0;
    for (int j = 0; j < N; j++) begin
      if (iv[(start + j) % N]) return (start + j) % N;
    end
    return -1;
  endfunction

  // Called at a negedge with inputs already applied; checks, then advances the model past the next posedge.
  task automatic run_cycle();
    logic [N-1:0] exp_rdy;
    logic [N-1:0] got_rdy;
    int g;
    bit reg_free;
    #1;
    for (int m = 0; m < 2; m++) begin
      if (!reset) begin
        m_active[m] = 0; m_vld[m] = 0; m_dat[m] = 0; m_sel[m] = 0; m_ptr[m] = 0;
      end
      reg_free = !m_vld[m] || out_ready;
      g = pick(m, in_valid);
      exp_rdy = '0;
      if (reset && m_active[m] && reg_free && g >= 0) exp_rdy[g] = 1'b1;
      got_rdy = (m == 0) ? rr_in_ready : fx_in_ready;
      chk(m == 0 ? "rr_in_ready" : "fx_in_ready", 32'(got_rdy), 32'(exp_rdy));
      chk(m == 0 ? "rr_out_valid" : "fx_out_valid",
          32'(m == 0 ? rr_out_valid : fx_out_valid), 32'(m_vld[m]));
      if (m_vld[m] || !reset) begin
        chk(m == 0 ? "rr_out" : "fx_out", 32'(m == 0 ? rr_out : fx_out), 32'(m_dat[m]));
        chk(m == 0 ? "rr_out_sel" : "fx_out_sel",
            32'(m == 0 ? rr_out_sel : fx_out_sel), 32'(m_sel[m]));
      end
      if (reset) begin
        if (!m_active[m]) begin
          m_active[m] = 1;
        end else if (reg_free && g >= 0) begin
          m_vld[m] = 1;
          m_dat[m] = int'(in_bus[g*W +: W]);
          m_sel[m] = g;
          m_ptr[m] = (g + 1) % N;
        end else if (m_vld[m] && out_ready) begin
          m_vld[m] = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_data_index();
    for (int k = 0; k < N; k++) in_bus[k*W +: W] = W'(k);
  endtask

  initial begin
    reset = 1'b0;
    in_bus = '0;
    in_valid = '0;
    out_ready = 1'b0;
    @(negedge clk);
    repeat (2) run_cycle();

    // Release edge must not transfer even with every channel valid.
    reset = 1'b1;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    run_cycle();

    // Single channel.
    in_valid = 8'b0000_1000;
    in_bus = '0;
    in_bus[3*W +: W] = 3'b011;
    run_cycle();
    in_valid = '0;
    chk("single_out", 32'(rr_out), 32'd3);
    chk("single_sel", 32'(rr_out_sel), 32'd3);
    run_cycle();

    // Round-robin fairness, fixed mode sees the same stream.
    set_data_index();
    in_valid = 8'hFF;
    repeat (10) run_cycle();

    // Fixed priority pattern.
    in_valid = 8'b0010_0110;
    repeat (6) run_cycle();
    chk("fixed_sel", 32'(fx_out_sel), 32'd1);

    // Backpressure with channel 2 held.
    in_valid = 8'b0000_0100;
    run_cycle();
    in_valid = 8'hFF;
    out_ready = 1'b0;
    repeat (4) run_cycle();
    chk("bp_hold_sel", 32'(rr_out_sel), 32'd2);
    out_ready = 1'b1;
    run_cycle();
    chk("bp_next_sel", 32'(rr_out_sel), 32'd3);

    // Pointer wrap.
    in_valid = 8'b0100_0000;
    run_cycle();
    in_valid = 8'b0000_0011;
    run_cycle();
    chk("wrap_first", 32'(rr_out_sel), 32'd0);
    run_cycle();
    chk("wrap_second", 32'(rr_out_sel), 32'd1);

    // Reset mid-operation with a held beat.
    in_valid = 8'hFF;
    out_ready = 1'b0;
    run_cycle();
    reset = 1'b0;
    run_cycle();
    run_cycle();
    reset = 1'b1;
    in_valid = 8'b1000_0001;
    out_ready = 1'b1;
    run_cycle();
    run_cycle();
    chk("post_reset_sel", 32'(rr_out_sel), 32'd0);

    // Random traffic with occasional reset.
    for (int t = 0; t < 600; t++) begin
      in_bus = W*N'($urandom);
      case ($urandom_range(0, 3))
        0: in_valid = N'($urandom);
        1: in_valid = N'(1 << $urandom_range(0, N-1));
        2: in_valid = 8'hFF;
        default: in_valid = N'($urandom) & N'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 99) != 0);
      run_cycle();
    end
    reset = 1'b1;
    run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
